// File: rtl/ssd_image_ram_arbiter_if.sv
// ssd_image_ram_arbiter_if
//  Bundles the three buses around the image RAM arbiter:
//   - cpu_*  Avalon-MM slave port seen by the Nios CPU (waitrequest/readdatavalid)
//   - eng_*  burst-read command and valid/ready output stream of the SSD engine
//   - ram_*  single-port RAM, 1-cycle read latency
//  Modports:
//   slave  - the arbiter's view (takes CPU/engine requests and RAM read data,
//            drives responses, the stream and the RAM command)
//   master - the surroundings' view (CPU, engine consumer and RAM model)
interface ssd_image_ram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic [BE_W-1:0]   cpu_byteenable;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_readdatavalid;

    logic              eng_start;
    logic [ADDR_W-1:0] eng_base;
    logic [ADDR_W:0]   eng_len;
    logic              eng_busy;
    logic              eng_done;
    logic [DATA_W-1:0] eng_data;
    logic              eng_valid;
    logic              eng_ready;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_write;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  eng_start, eng_base, eng_len, eng_ready,
        output eng_busy, eng_done, eng_data, eng_valid,
        output ram_address, ram_byteenable, ram_writedata, ram_write,
        input  ram_readdata
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output eng_start, eng_base, eng_len, eng_ready,
        input  eng_busy, eng_done, eng_data, eng_valid,
        input  ram_address, ram_byteenable, ram_writedata, ram_write,
        output ram_readdata
    );
endinterface

// File: rtl/ssd_image_ram_arbiter.sv
// ssd_image_ram_arbiter
//  Shares one single-port image RAM (1-cycle read latency) between the Nios
//  CPU (Avalon-MM slave) and the SSD engine's burst-read streamer. One RAM
//  access is issued per cycle; while the engine streams, a pending CPU request
//  is granted after at most SLICE consecutive engine reads, or immediately if
//  the engine cannot issue this cycle.
//  Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   bus      - ssd_image_ram_arbiter_if.slave: cpu_* Avalon port, eng_* burst
//              command + valid/ready stream, ram_* RAM port
module ssd_image_ram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int SLICE  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ssd_image_ram_arbiter_if.slave        bus
);
    localparam int SLICE_W = $clog2(SLICE + 1);
    localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [SLICE_W-1:0] SLICE_ONE = SLICE_W'(1);
    localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(SLICE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENG,
        ST_DRAIN
    } state_t;

    state_t state_reg, state_next;

    // Burst bookkeeping
    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W:0]    len_reg;
    logic [ADDR_W:0]    issued_reg;
    logic [ADDR_W:0]    accepted_reg;
    logic [SLICE_W-1:0] slice_cnt_reg;

    // 2-entry engine output FIFO
    logic [DATA_W-1:0]  fifo_mem_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         fifo_count_reg;

    // In-flight tags: which requester owns the read data arriving this cycle.
    // cpu_rdv_reg doubles as cpu_readdatavalid.
    logic               inflight_eng_reg;
    logic               cpu_rdv_reg;
    logic [DATA_W-1:0]  cpu_readdata_reg;
    logic               eng_done_reg;

    logic               cpu_req;
    logic               cpu_grant;
    logic               eng_can;
    logic               eng_issue;
    logic               fifo_pop;
    logic               start_burst;
    logic               done_next;
    logic [1:0]         occupancy;
    logic               credit_ok;

    assign cpu_req  = bus.cpu_read | bus.cpu_write;
    assign fifo_pop = (fifo_count_reg != 2'd0) & bus.eng_ready;

    // Words buffered plus the one read in flight, less a word leaving this
    // cycle. Counting the same-cycle pop keeps the stream back-to-back under
    // eng_ready=1 while still never exceeding the two FIFO entries.
    assign occupancy = fifo_count_reg + {1'b0, inflight_eng_reg} - {1'b0, fifo_pop};
    assign credit_ok = occupancy < 2'd2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cpu_grant   = 1'b0;
        eng_can     = 1'b0;
        eng_issue   = 1'b0;
        start_burst = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cpu_grant = cpu_req;
                if (bus.eng_start) begin
                    if (bus.eng_len != '0) begin
                        start_burst = 1'b1;
                        state_next  = ST_ENG;
                    end else begin
                        // Empty burst completes without touching the RAM
                        done_next = 1'b1;
                    end
                end
            end
            ST_ENG: begin
                eng_can   = credit_ok && (issued_reg != len_reg);
                cpu_grant = cpu_req && ((slice_cnt_reg == SLICE_MAX) || !eng_can);
                eng_issue = eng_can && !cpu_grant;
                if (eng_issue && ((issued_reg + CNT_ONE) == len_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cpu_grant = cpu_req;
                if (accepted_reg == len_reg) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg         <= '0;
            len_reg          <= '0;
            issued_reg       <= '0;
            accepted_reg     <= '0;
            slice_cnt_reg    <= '0;
            fifo_mem_reg[0]  <= '0;
            fifo_mem_reg[1]  <= '0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            fifo_count_reg   <= 2'd0;
            inflight_eng_reg <= 1'b0;
            cpu_rdv_reg      <= 1'b0;
            cpu_readdata_reg <= '0;
            eng_done_reg     <= 1'b0;
        end else begin
            eng_done_reg     <= done_next;
            inflight_eng_reg <= eng_issue;
            // A simultaneous read+write is a write, so no read data returns
            cpu_rdv_reg      <= cpu_grant & bus.cpu_read & ~bus.cpu_write;
            if (cpu_rdv_reg) begin
                cpu_readdata_reg <= bus.ram_readdata;
            end

            if (start_burst) begin
                addr_reg     <= bus.eng_base;
                len_reg      <= bus.eng_len;
                issued_reg   <= '0;
                accepted_reg <= '0;
            end else begin
                if (eng_issue) begin
                    addr_reg   <= addr_reg + ADDR_ONE;
                    issued_reg <= issued_reg + CNT_ONE;
                end
                if (fifo_pop) begin
                    accepted_reg <= accepted_reg + CNT_ONE;
                end
            end

            // Counts engine reads issued ahead of a waiting CPU request only
            if (cpu_grant || !cpu_req) begin
                slice_cnt_reg <= '0;
            end else if (eng_issue) begin
                slice_cnt_reg <= slice_cnt_reg + SLICE_ONE;
            end

            if (inflight_eng_reg) begin
                fifo_mem_reg[wr_ptr_reg] <= bus.ram_readdata;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({inflight_eng_reg, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    assign bus.cpu_waitrequest   = cpu_req & ~cpu_grant;
    assign bus.cpu_readdatavalid = cpu_rdv_reg;
    // RAM data arrives in the valid cycle itself; the register holds the last
    // read value afterwards and is 0 out of reset.
    assign bus.cpu_readdata      = cpu_rdv_reg ? bus.ram_readdata : cpu_readdata_reg;

    assign bus.eng_busy  = (state_reg != ST_IDLE);
    assign bus.eng_done  = eng_done_reg;
    assign bus.eng_valid = (fifo_count_reg != 2'd0);
    assign bus.eng_data  = fifo_mem_reg[rd_ptr_reg];

    assign bus.ram_address    = cpu_grant ? bus.cpu_address : addr_reg;
    assign bus.ram_write      = cpu_grant & bus.cpu_write;
    assign bus.ram_byteenable = cpu_grant ? bus.cpu_byteenable : '1;
    assign bus.ram_writedata  = bus.cpu_writedata;
endmodule

// File: tb/tb_ssd_image_ram_arbiter.sv
// tb_ssd_image_ram_arbiter
//  Directed bench for ssd_image_ram_arbiter. A behavioural RAM returns
//  pat(addr) for never-written words and merges byte-enabled writes.
//  Inputs change 1 ns after the rising edge; outputs are sampled on the
//  falling edge.
module tb_ssd_image_ram_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int SLICE  = 16;

    logic clk;
    logic reset_n;

    ssd_image_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    ssd_image_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .SLICE(SLICE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pat(input logic [17:0] a);
        return {~a[13:0], a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural RAM, 1-cycle read latency
    logic [31:0] mem     [0:262143];
    bit          written [0:262143];
    always @(posedge clk) begin
        if (bus.ram_write) begin
            mem[bus.ram_address] <= merge(written[bus.ram_address] ? mem[bus.ram_address]
                                          : pat(bus.ram_address),
                                          bus.ram_writedata, bus.ram_byteenable);
            written[bus.ram_address] <= 1'b1;
        end
        bus.ram_readdata <= written[bus.ram_address] ? mem[bus.ram_address]
                            : pat(bus.ram_address);
    end

    // Stream / event monitor
    logic [31:0] beats[$];
    int          beat_cyc[$];
    int          done_cnt = 0;
    int          wr_cnt   = 0;
    int          cyc      = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (bus.eng_valid && bus.eng_ready) begin
                beats.push_back(bus.eng_data);
                beat_cyc.push_back(cyc);
            end
            if (bus.eng_done)  done_cnt <= done_cnt + 1;
            if (bus.ram_write) wr_cnt   <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eng_go(input logic [17:0] b, input logic [18:0] l);
        bus.eng_base  = b;
        bus.eng_len   = l;
        bus.eng_start = 1'b1;
        step();
        bus.eng_start = 1'b0;
    endtask

    // One Avalon access; returns cycles spent in waitrequest and, for a read,
    // readdatavalid/readdata one cycle after acceptance.
    task automatic cpu_access(input logic wr, input logic [17:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int waited,
                              output logic [31:0] rdata, output logic rdv);
        bus.cpu_address    = a;
        bus.cpu_writedata  = d;
        bus.cpu_byteenable = be;
        bus.cpu_write      = wr;
        bus.cpu_read       = ~wr;
        waited = 0;
        @(negedge clk);
        while (bus.cpu_waitrequest && waited < 64) begin
            waited++;
            @(negedge clk);
        end
        step();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        @(negedge clk);
        rdv   = bus.cpu_readdatavalid;
        rdata = bus.cpu_readdata;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        for (int c = 0; c < budget && done_cnt == d0; c++) step();
        repeat (3) step();
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_beats(input string tag, input logic [17:0] base, input int n);
        chk({tag, "_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), beats[i], pat(base + 18'(i)));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w, d0, w0, maxw;
        logic [31:0] rd;
        logic        rv;

        reset_n            = 1'b0;
        bus.cpu_address    = '0;
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_writedata  = '0;
        bus.cpu_byteenable = '0;
        bus.eng_start      = 1'b0;
        bus.eng_base       = '0;
        bus.eng_len        = '0;
        bus.eng_ready      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus.eng_busy), 32'd0);
        chk("rst_done",  32'(bus.eng_done), 32'd0);
        chk("rst_valid", 32'(bus.eng_valid), 32'd0);
        chk("rst_rdv",   32'(bus.cpu_readdatavalid), 32'd0);
        chk("rst_rdata", bus.cpu_readdata, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // 1: reset in the middle of a stalled burst
        d0 = done_cnt;
        eng_go(18'h00100, 19'd8);
        repeat (4) step();
        @(negedge clk);
        chk("t1_busy_before", 32'(bus.eng_busy), 32'd1);
        chk("t1_valid_before", 32'(bus.eng_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t1_busy_in_reset", 32'(bus.eng_busy), 32'd0);
        chk("t1_valid_in_reset", 32'(bus.eng_valid), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("t1_no_done", 32'(done_cnt - d0), 32'd0);
        beats.delete(); beat_cyc.delete();
        bus.eng_ready = 1'b1;
        d0 = done_cnt;
        eng_go(18'h00100, 19'd2);
        wait_done("t1_restart_done", d0, 100);
        check_beats("t1_restart", 18'h00100, 2);

        // 2: byte-enabled write then read-back
        beats.delete(); beat_cyc.delete();
        w0 = wr_cnt;
        cpu_access(1'b1, 18'h00010, 32'hDEADBEEF, 4'b0011, w, rd, rv);
        chk("t2_wr_wait", 32'(w), 32'd0);
        chk("t2_wr_nordv", 32'(rv), 32'd0);
        step();
        cpu_access(1'b0, 18'h00010, 32'h0, 4'hF, w, rd, rv);
        chk("t2_rd_rdv", 32'(rv), 32'd1);
        chk("t2_rd_data", rd, 32'hFFBCBEEF);
        @(negedge clk);
        chk("t2_rdv_one_cycle", 32'(bus.cpu_readdatavalid), 32'd0);
        chk("t2_one_ram_write", 32'(wr_cnt - w0), 32'd1);
        step();

        // 3: address wrap, back-to-back beats
        beats.delete(); beat_cyc.delete();
        bus.eng_ready = 1'b1;
        d0 = done_cnt;
        eng_go(18'h3FFFE, 19'd4);
        wait_done("t3_done_once", d0, 100);
        check_beats("t3", 18'h3FFFE, 4);
        if (beat_cyc.size() >= 4) begin
            chk("t3_back_to_back", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
        end
        chk("t3_busy_after", 32'(bus.eng_busy), 32'd0);

        // 4: long burst with the CPU reading throughout
        beats.delete(); beat_cyc.delete();
        d0   = done_cnt;
        maxw = 0;
        eng_go(18'h01000, 19'd40);
        for (int k = 0; k < 8; k++) begin
            if (k > 0 && !bus.eng_busy) break;
            cpu_access(1'b0, 18'h20000 + 18'(k), 32'h0, 4'hF, w, rd, rv);
            chk($sformatf("t4_cpu_rd%0d", k), rd, pat(18'h20000 + 18'(k)));
            if (w > maxw) maxw = w;
            step();
        end
        chk("t4_max_wait_capped", 32'((maxw <= SLICE) ? SLICE : maxw), 32'(SLICE));
        wait_done("t4_done_once", d0, 400);
        check_beats("t4", 18'h01000, 40);

        // 5: random backpressure with a CPU read in the middle
        beats.delete(); beat_cyc.delete();
        d0 = done_cnt;
        eng_go(18'h00040, 19'd6);
        fork
            begin
                for (int c = 0; c < 300 && done_cnt == d0; c++) begin
                    bus.eng_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
            begin
                repeat (3) step();
                cpu_access(1'b0, 18'h00050, 32'h0, 4'hF, w, rd, rv);
                chk("t5_cpu_rd", rd, pat(18'h00050));
                chk("t5_cpu_wait", 32'((w <= SLICE) ? SLICE : w), 32'(SLICE));
            end
        join
        bus.eng_ready = 1'b1;
        wait_done("t5_done_once", d0, 200);
        check_beats("t5", 18'h00040, 6);

        // 6: empty burst, then start while busy
        beats.delete(); beat_cyc.delete();
        d0 = done_cnt;
        w0 = wr_cnt;
        eng_go(18'h00077, 19'd0);
        @(negedge clk);
        chk("t6_len0_done", 32'(bus.eng_done), 32'd1);
        chk("t6_len0_busy", 32'(bus.eng_busy), 32'd0);
        step();
        @(negedge clk);
        chk("t6_len0_done_pulse", 32'(bus.eng_done), 32'd0);
        chk("t6_len0_busy2", 32'(bus.eng_busy), 32'd0);
        chk("t6_len0_no_beats", 32'(beats.size()), 32'd0);
        chk("t6_len0_no_write", 32'(wr_cnt - w0), 32'd0);
        step();
        bus.eng_ready = 1'b0;
        d0 = done_cnt;
        eng_go(18'h00300, 19'd3);
        repeat (2) step();
        eng_go(18'h00500, 19'd5);
        repeat (2) step();
        bus.eng_ready = 1'b1;
        wait_done("t6_busy_start_done", d0, 100);
        check_beats("t6", 18'h00300, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
